mem_port_arbiter: RTL and testbench

Sequencer and arbiter that shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch (IF) stage and its data-memory (MEM) stage. It accepts level-held requests from both stages and grants one at a time. It drives the memory's command bus, captures the read data and returns a one-cycle completion pulse. It raises per-stage stall signals that the pipeline control uses to freeze IF or MEM while their access is outstanding.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory sequencer shared by the IF and MEM pipeline stages.
// Optional round-robin arbitration when compiled with MEM_ARB_RR_EN.
module mem_port_arbiter #(
  parameter int AW  = 64,
  parameter int DW  = 64,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  output logic          if_stall,
  input  logic          dm_re,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          dm_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t        state, state_d;
  logic [3:0]    cnt, cnt_d;
  logic          gnt_dm, gnt_dm_d;
  logic          wr, wr_d;
  logic          mem_en_d, mem_we_d, if_valid_d, dm_valid_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d, if_rdata_d, dm_rdata_d;
  logic          dm_pend, pick_dm;

  assign dm_pend  = dm_re | dm_we;
  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_pend & ~dm_valid;

`ifdef MEM_ARB_RR_EN
  logic last_dm, last_dm_d;
  // On a tie the port not granted last time wins.
  assign pick_dm = dm_pend & (~if_req | ~last_dm);
`else
  assign pick_dm = dm_pend;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      gnt_dm    <= 1'b0;
      wr        <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
`ifdef MEM_ARB_RR_EN
      last_dm   <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      gnt_dm    <= gnt_dm_d;
      wr        <= wr_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      if_valid  <= if_valid_d;
      dm_valid  <= dm_valid_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_dm   <= last_dm_d;
`endif
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    gnt_dm_d   = gnt_dm;
    wr_d       = wr;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
    if_rdata_d = if_rdata;
    dm_rdata_d = dm_rdata;
`ifdef MEM_ARB_RR_EN
    last_dm_d  = last_dm;
`endif
    unique case (state)
      IDLE: begin
        if (dm_pend | if_req) begin
          gnt_dm_d = pick_dm;
          wr_d     = pick_dm & dm_we;
          addr_d   = pick_dm ? dm_addr : if_addr;
          wdata_d  = pick_dm ? dm_wdata : '0;
          mem_en_d = 1'b1;
          mem_we_d = pick_dm & dm_we;
          state_d  = ISSUE;
`ifdef MEM_ARB_RR_EN
          last_dm_d = pick_dm;
`endif
        end
      end
      ISSUE: begin
        // Data is valid LAT cycles after the strobe, so WAIT always runs
        // LAT cycles, even for LAT=1.
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          if (!wr) begin
            if (gnt_dm) dm_rdata_d = mem_rdata;
            else        if_rdata_d = mem_rdata;
          end
          dm_valid_d = gnt_dm;
          if_valid_d = ~gnt_dm;
          state_d    = RESP;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a LAT=2 and a LAT=1 instance, directed vectors, monitor-side checking.
module tb_mem_port_arbiter;

  localparam logic [63:0] STALE = 64'hDEAD_BEEF_0BAD_0BAD;

  typedef struct {
    bit          port;   // 1 = data port
    logic [63:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  exp_t q0[$], q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // LAT=2 instance signals
  logic        if_req0, dm_re0, dm_we0;
  logic [63:0] if_addr0, dm_addr0, dm_wdata0, if_rdata0, dm_rdata0;
  logic        if_valid0, if_stall0, dm_valid0, dm_stall0, mem_en0, mem_we0;
  logic [63:0] mem_addr0, mem_wdata0, mem_rdata0, p0a, p0b;
  // LAT=1 instance signals
  logic        if_req1, dm_re1, dm_we1;
  logic [63:0] if_addr1, dm_addr1, dm_wdata1, if_rdata1, dm_rdata1;
  logic        if_valid1, if_stall1, dm_valid1, dm_stall1, mem_en1, mem_we1;
  logic [63:0] mem_addr1, mem_wdata1, mem_rdata1, p1a;

  mem_port_arbiter #(.AW(64), .DW(64), .LAT(2)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req0), .if_addr(if_addr0), .if_rdata(if_rdata0), .if_valid(if_valid0), .if_stall(if_stall0),
    .dm_re(dm_re0), .dm_we(dm_we0), .dm_addr(dm_addr0), .dm_wdata(dm_wdata0), .dm_rdata(dm_rdata0),
    .dm_valid(dm_valid0), .dm_stall(dm_stall0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
  );

  mem_port_arbiter #(.AW(64), .DW(64), .LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_valid(if_valid1), .if_stall(if_stall1),
    .dm_re(dm_re1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1), .dm_rdata(dm_rdata1),
    .dm_valid(dm_valid1), .dm_stall(dm_stall1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  function automatic logic [63:0] lookup(input logic [63:0] a);
    case (a)
      64'h40:  return 64'hF840_03E1;
      64'h8:   return 64'h5;
      default: return a ^ 64'hA5A5_0000_0000_0000;
    endcase
  endfunction

  // Memory models: read data appears exactly LAT cycles after mem_en, junk otherwise.
  always @(negedge clk) begin
    mem_rdata0 = p0b;
    p0b = p0a;
    p0a = (mem_en0 === 1'b1 && mem_we0 === 1'b0) ? lookup(mem_addr0) : STALE;
    mem_rdata1 = p1a;
    p1a = (mem_en1 === 1'b1 && mem_we1 === 1'b0) ? lookup(mem_addr1) : STALE;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic sb_check(input int d, input bit port, input logic [63:0] rd);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_valid: dut%0d port %0d got valid, want none (cycle %0d)", d, port, cyc);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk("sb_port", 64'(port), 64'(e.port));
    chk("sb_cycle", 64'(cyc), 64'(e.cyc));
    chk("sb_rdata", rd, e.rdata);
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (if_valid0) sb_check(0, 1'b0, if_rdata0);
      if (dm_valid0) sb_check(0, 1'b1, dm_rdata0);
      if (if_valid1) sb_check(1, 1'b0, if_rdata1);
      if (dm_valid1) sb_check(1, 1'b1, dm_rdata1);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic goto(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic dm_txn(input bit we, input logic [63:0] a, input logic [63:0] wd, input logic [63:0] exp_rd);
    int c0;
    step(); c0 = cyc;
    dm_we0 = we; dm_re0 = ~we; dm_addr0 = a; dm_wdata0 = wd;
    q0.push_back('{1'b1, exp_rd, c0 + 4});
    goto(c0 + 1);
    chk("dm_mem_en", 64'(mem_en0), 64'd1);
    chk("dm_mem_we", 64'(mem_we0), 64'(we));
    chk("dm_mem_addr", mem_addr0, a);
    if (we) chk("dm_mem_wdata", mem_wdata0, wd);
    goto(c0 + 3); chk("dm_stall_busy", 64'(dm_stall0), 64'd1);
    goto(c0 + 4); chk("dm_stall_valid", 64'(dm_stall0), 64'd0);
    step(); dm_re0 = 0; dm_we0 = 0;
  endtask

  initial begin
    int c0;
    bit dm_first;
    reset_n = 0;
    if_req0 = 1; if_addr0 = 64'h40; dm_re0 = 0; dm_we0 = 0; dm_addr0 = 0; dm_wdata0 = 0;
    if_req1 = 0; if_addr1 = 0; dm_re1 = 0; dm_we1 = 0; dm_addr1 = 0; dm_wdata1 = 0;
    p0a = STALE; p0b = STALE; p1a = STALE;

    // Reset held two cycles with a fetch pending
    @(posedge clk); @(posedge clk); #1;
    chk("rst_mem_en", 64'(mem_en0), 64'd0);
    chk("rst_mem_we", 64'(mem_we0), 64'd0);
    chk("rst_if_valid", 64'(if_valid0), 64'd0);
    chk("rst_dm_valid", 64'(dm_valid0), 64'd0);
    chk("rst_if_rdata", if_rdata0, 64'd0);
    chk("rst_dm_rdata", dm_rdata0, 64'd0);
    chk("rst_mem_addr", mem_addr0, 64'd0);
    chk("rst_mem_en1", 64'(mem_en1), 64'd0);

    // Release; the pending fetch is cycle 0
    reset_n = 1; c0 = cyc;
    q0.push_back('{1'b0, 64'hF840_03E1, c0 + 4});
    for (int k = 0; k <= 4; k++) begin
      goto(c0 + k);
      chk($sformatf("fetch_stall_c%0d", k), 64'(if_stall0), 64'(k < 4));
      chk($sformatf("fetch_mem_en_c%0d", k), 64'(mem_en0), 64'(k == 1));
    end
    step(); if_req0 = 0;

    // Load then store: the store must leave dm_rdata at the loaded value
    dm_txn(1'b0, 64'h200, 64'h0, 64'hA5A5_0000_0000_0200);
    dm_txn(1'b1, 64'h100, 64'hDEAD, 64'hA5A5_0000_0000_0200);

    // Simultaneous requests
`ifdef MEM_ARB_RR_EN
    dm_first = 1'b0;
`else
    dm_first = 1'b1;
`endif
    step(); c0 = cyc;
    if_req0 = 1; if_addr0 = 64'h40; dm_re0 = 1; dm_addr0 = 64'h300;
    if (dm_first) begin
      q0.push_back('{1'b1, 64'hA5A5_0000_0000_0300, c0 + 4});
      q0.push_back('{1'b0, 64'hF840_03E1, c0 + 9});
    end else begin
      q0.push_back('{1'b0, 64'hF840_03E1, c0 + 4});
      q0.push_back('{1'b1, 64'hA5A5_0000_0000_0300, c0 + 9});
    end
    goto(c0 + 1); chk("pair_first_addr", mem_addr0, dm_first ? 64'h300 : 64'h40);
    goto(c0 + 4); chk("pair_loser_stall", 64'(dm_first ? if_stall0 : dm_stall0), 64'd1);
    step();
    if (dm_first) dm_re0 = 0; else if_req0 = 0;
    goto(c0 + 5); chk("pair_gap_mem_en", 64'(mem_en0), 64'd0);
    goto(c0 + 6);
    chk("pair_second_mem_en", 64'(mem_en0), 64'd1);
    chk("pair_second_addr", mem_addr0, dm_first ? 64'h40 : 64'h300);
    goto(c0 + 9); chk("pair_second_stall", 64'(dm_first ? if_stall0 : dm_stall0), 64'd0);
    step(); if_req0 = 0; dm_re0 = 0;

    // Reset during WAIT: no valid, stale data not captured
    step(); c0 = cyc;
    dm_re0 = 1; dm_addr0 = 64'h500;
    goto(c0 + 1); step();
    reset_n = 0; dm_re0 = 0;
    goto(c0 + 2); chk("midrst_wait_mem_en", 64'(mem_en0), 64'd0);
    step(); reset_n = 1;
    goto(c0 + 3);
    chk("midrst_dm_rdata", dm_rdata0, 64'd0);
    chk("midrst_mem_addr", mem_addr0, 64'd0);
    chk("midrst_mem_en", 64'(mem_en0), 64'd0);
    goto(c0 + 5);
    chk("midrst_dm_rdata_late", dm_rdata0, 64'd0);
    chk("midrst_no_valid", 64'(dm_valid0), 64'd0);

    // LAT=1 instance
    step(); c0 = cyc;
    dm_re1 = 1; dm_addr1 = 64'h8;
    q1.push_back('{1'b1, 64'h5, c0 + 3});
    goto(c0 + 1); chk("lat1_mem_en", 64'(mem_en1), 64'd1);
    goto(c0 + 2);
    chk("lat1_mem_en_off", 64'(mem_en1), 64'd0);
    chk("lat1_stall", 64'(dm_stall1), 64'd1);
    goto(c0 + 3); step(); dm_re1 = 0;

    goto(cyc + 4);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
